// File: rtl/qoi_pkg.sv
// Shared opcode constants, decoder state encoding and the colour-index hash
// for the QOI stream decoder.
package qoi_pkg;

  localparam logic [1:0] OP_INDEX = 2'b00;
  localparam logic [1:0] OP_DIFF  = 2'b01;
  localparam logic [1:0] OP_LUMA  = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;
  localparam logic [7:0] OP_RGB   = 8'hFE;
  localparam logic [7:0] OP_END   = 8'hFF;

  typedef enum logic [2:0] {
    S_OP,
    S_RGB,
    S_LUMA2,
    S_EMIT,
    S_RUN,
    S_DONE
  } state_t;

  // Sum is formed at CW+3 bits before folding into the table depth.
  function automatic logic [5:0] qoi_hash(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b, input int unsigned cw,
                                          input int unsigned depth);
    logic [11:0] sum;
    logic [11:0] mask;
    sum  = 12'(r) * 12'd3 + 12'(g) * 12'd5 + 12'(b) * 12'd7;
    mask = 12'((1 << (cw + 3)) - 1);
    return 6'((sum & mask) & 12'(depth - 1));
  endfunction

endpackage

// File: rtl/qoi_index_table.sv
// Recently-seen pixel table: flop array with synchronous write and clear,
// asynchronous read so INDEX ops resolve in the opcode cycle.
module qoi_index_table #(
  parameter int unsigned PW    = 12,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [PW-1:0] rdata
);

  logic [PW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qoi_stream_decoder.sv
// QOI byte-stream to {r,g,b} pixel decoder with valid/ready on both sides.
// Optional QOI_DEC_PIXLIMIT_EN: end the frame after NUM_PIXELS emitted pixels.
module qoi_stream_decoder
  import qoi_pkg::*;
#(
  parameter int unsigned CW         = 4,
  parameter int unsigned IDX_DEPTH  = 64,
  parameter int unsigned NUM_PIXELS = 1280 * 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [3*CW-1:0] pix_out,
  output logic            pix_valid,
  input  logic            pix_ready,
  output logic            done
);

  localparam int unsigned PW = 3 * CW;
  localparam int unsigned NB = (PW + 7) / 8;
  localparam int unsigned AB = NB * 8;
  localparam int unsigned AW = $clog2(IDX_DEPTH);

  if (CW < 1 || CW > 8 || IDX_DEPTH < 2 || IDX_DEPTH > 64 ||
      (IDX_DEPTH & (IDX_DEPTH - 1)) != 0 || NUM_PIXELS < 1 || NUM_PIXELS >= 2 ** 21)
  begin : g_bad_params
    $error("qoi_stream_decoder: parameter out of range");
  end

  state_t        state;
  logic [PW-1:0] prev;
  logic [AB-1:0] acc;
  logic [AB-1:0] acc_next;
  logic [1:0]    rgb_left;
  logic [7:0]    luma_dg;
  logic [5:0]    run_left;
  logic          byte_take;
  logic          emit;
  logic [PW-1:0] new_pix;
  logic [PW-1:0] tbl_rdata;
  logic [AW-1:0] wr_addr;
  logic          limit_hit;

  function automatic logic [PW-1:0] add_delta(input logic [PW-1:0] p, input logic [7:0] dr,
                                              input logic [7:0] dg, input logic [7:0] db);
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    r8 = 8'(p[PW-1:2*CW]) + dr;
    g8 = 8'(p[2*CW-1:CW]) + dg;
    b8 = 8'(p[CW-1:0]) + db;
    return {r8[CW-1:0], g8[CW-1:0], b8[CW-1:0]};
  endfunction

  assign in_ready  = en && (state == S_OP || state == S_RGB || state == S_LUMA2);
  assign byte_take = in_valid && in_ready;
  assign acc_next  = (acc << 8) | AB'(in_data);

  always_comb begin
    emit    = 1'b0;
    new_pix = prev;
    case (state)
      S_OP: begin
        if (byte_take && in_data != OP_RGB && in_data != OP_END) begin
          case (in_data[7:6])
            OP_INDEX: begin
              emit    = 1'b1;
              new_pix = tbl_rdata;
            end
            OP_DIFF: begin
              emit    = 1'b1;
              new_pix = add_delta(prev, 8'(in_data[5:4]) - 8'd2,
                                  8'(in_data[3:2]) - 8'd2, 8'(in_data[1:0]) - 8'd2);
            end
            OP_RUN: emit = 1'b1;
            default: ;
          endcase
        end
      end
      S_RGB: begin
        if (byte_take && rgb_left == 2'd1) begin
          emit    = 1'b1;
          new_pix = acc_next[PW-1:0];
        end
      end
      S_LUMA2: begin
        if (byte_take) begin
          emit    = 1'b1;
          new_pix = add_delta(prev, luma_dg + 8'(in_data[7:4]) - 8'd8, luma_dg,
                              luma_dg + 8'(in_data[3:0]) - 8'd8);
        end
      end
      default: ;
    endcase
  end

  // Every emitted pixel (a run's only on entry) lands in the table at its hash.
  assign wr_addr = AW'(qoi_hash(8'(new_pix[PW-1:2*CW]), 8'(new_pix[2*CW-1:CW]),
                                8'(new_pix[CW-1:0]), CW, IDX_DEPTH));

  qoi_index_table #(
    .PW   (PW),
    .DEPTH(IDX_DEPTH),
    .AW   (AW)
  ) u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (en && emit),
    .waddr(wr_addr),
    .wdata(new_pix),
    .raddr(in_data[AW-1:0]),
    .rdata(tbl_rdata)
  );

`ifdef QOI_DEC_PIXLIMIT_EN
  logic [20:0] pix_cnt;
  assign limit_hit = (pix_cnt == 21'(NUM_PIXELS - 1));

  always_ff @(posedge clk) begin
    if (rst) pix_cnt <= '0;
    else if (en && pix_valid && pix_ready) pix_cnt <= pix_cnt + 21'd1;
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OP;
      prev      <= '0;
      acc       <= '0;
      rgb_left  <= '0;
      luma_dg   <= '0;
      run_left  <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      done      <= 1'b0;
    end else if (en) begin
      if (emit) begin
        prev      <= new_pix;
        pix_out   <= new_pix;
        pix_valid <= 1'b1;
      end
      case (state)
        S_OP: begin
          if (byte_take) begin
            if (in_data == OP_END) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (in_data == OP_RGB) begin
              state    <= S_RGB;
              acc      <= '0;
              rgb_left <= 2'(NB);
            end else begin
              case (in_data[7:6])
                OP_LUMA: begin
                  luma_dg <= 8'(in_data[5:0]) - 8'd32;
                  state   <= S_LUMA2;
                end
                OP_RUN: begin
                  run_left <= in_data[5:0];
                  state    <= S_RUN;
                end
                default: state <= S_EMIT;
              endcase
            end
          end
        end
        S_RGB: begin
          if (byte_take) begin
            acc      <= acc_next;
            rgb_left <= rgb_left - 2'd1;
            if (rgb_left == 2'd1) state <= S_EMIT;
          end
        end
        S_LUMA2: begin
          if (byte_take) state <= S_EMIT;
        end
        S_EMIT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (limit_hit) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_OP;
            end
          end
        end
        S_RUN: begin
          if (pix_ready) begin
            if (limit_hit) begin
              pix_valid <= 1'b0;
              state     <= S_DONE;
              done      <= 1'b1;
            end else if (run_left == 6'd0) begin
              pix_valid <= 1'b0;
              state     <= S_OP;
            end else begin
              run_left <= run_left - 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/qoi_stream_decoder.md
Name: qoi_stream_decoder

Overview:
- Parametrised successor to the fixed-array RGB444 QOI decoder.
- Consumes a QOI-style byte stream over a valid/ready handshake, one byte per cycle.
- Emits one decoded pixel per output beat, 3*CW bits wide, over valid/ready.
- Sits between the frame-buffer byte reader and the VGA pixel path; CW is configurable and the index table depth is parametrised.

Parameters:
- CW, 4, bits per colour channel (1..8); pixel = {r,g,b}, 3*CW bits.
- IDX_DEPTH, 64, index table entries (power of 2, 2..64).
- NUM_PIXELS, 1280*1024, frame pixel limit (used only with QOI_DEC_PIXLIMIT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global enable; when 0 all state freezes and in_ready=0.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid&&in_ready.
- pix_out  out  3*CW  decoded pixel {r,g,b}.
- pix_valid  out  1  pix_out valid.
- pix_ready  in  1  sink accepts pixel.
- done  out  1  end marker (or pixel limit) reached; sticky until rst.

Behaviour:
- Reset: on the clock edge with rst=1, all outputs go to 0, state=S_OP, prev pixel=0, all index entries=0, run count=0.

Opcodes (first byte):
- 0xFF: END.
- 0xFE: RGB. Followed by NB=ceil(3*CW/8) bytes, MSB first; pixel = low 3*CW bits.
- 00iiiiii: INDEX. Pixel = table[i mod IDX_DEPTH].
- 01rrggbb: DIFF. Each 2-bit field minus 2 is added to prev.
- 10gggggg: LUMA, two bytes. dg = g-32. Second byte rrrrbbbb: dr = dg + rrrr - 8, db = dg + bbbb - 8.
- 11rrrrrr (r<=61): RUN. prev is repeated r+1 times.

Arithmetic and hashing:
- All channel arithmetic is modulo 2^CW: sign-extend the deltas, then truncate.
- hash = (3r + 5g + 7b) mod IDX_DEPTH, computed at CW+3 bits.
- Every emitted pixel is written to table[hash] and to prev.

States:
- S_OP: waits for an opcode byte.
  - RGB -> S_RGB (count NB bytes).
  - LUMA -> S_LUMA2.
  - INDEX/DIFF -> S_EMIT.
  - RUN -> S_RUN.
  - END -> S_DONE.
- S_RGB, S_LUMA2: once the final byte is taken -> S_EMIT.
- S_EMIT: pix_valid=1 on the cycle after the last byte of the op is accepted (latency 1). On the handshake -> S_OP.
- S_RUN: pix_valid stays high with pix_out=prev for r+1 handshakes, then -> S_OP.
- S_DONE: in_ready=0, done=1.

Handshake rules:
- in_ready = en && state in {S_OP, S_RGB, S_LUMA2}.
- pix_out and pix_valid hold stable while pix_valid && !pix_ready.
- The table/prev update is performed when the pixel is registered; a run writes the table once.
- INDEX reads the table combinationally, so no bubble is added.
- Back-to-back single-byte ops sustain 1 pixel every 2 cycles. Single-byte ops do not overlap with emission.

Boundary conditions:
- en=0 mid-run: the run count and pix_valid hold.
- rst mid-op or mid-run: everything returns to reset values on that edge. Partial RGB bytes are discarded.
- INDEX with i >= IDX_DEPTH: i wraps modulo IDX_DEPTH.
- Bytes offered after done are not accepted.

Optional Feature:
- QOI_DEC_PIXLIMIT_EN defined: a 21-bit emitted-pixel counter is kept.
  - When the NUM_PIXELS-th pixel handshakes, the decoder enters S_DONE even without 0xFF.
  - A run crossing the limit is truncated at the limit.
- Without the macro: no counter; only 0xFF ends the frame.

Decomposition:
- Package qoi_pkg holds:
  - op prefix constants (OP_INDEX=2'b00, OP_DIFF=2'b01, OP_LUMA=2'b10, OP_RUN=2'b11, OP_RGB=8'hFE, OP_END=8'hFF);
  - the state enum;
  - the hash function parametrised by CW/IDX_DEPTH.
- Sub-module qoi_index_table: IDX_DEPTH x 3*CW flop array, synchronous write, asynchronous read, synchronous clear on rst.

Test Plan (CW=4, IDX_DEPTH=64):
1. After rst: FE,0A,BC -> pix_out=0xABC one cycle after 0xBC is accepted; hash=41. Then 0x29 -> pix_out=0xABC.
2. prev=0xABC, byte 0x79 (DIFF +1,0,-1) -> pix_out=0xBBB. Then 0xC2 -> three beats of 0xBBB. Holding pix_ready=0 for 2 cycles mid-run keeps pix_out/pix_valid stable and in_ready=0.
3. After rst: A2,97 (LUMA dg=+2, dr=+3, db=+1) -> pix_out=0x321.
4. Wrap-around: prev=0xF0F, byte 0x7B -> pix_out=0x000.
5. Byte 0xFF -> done=1 next cycle and in_ready=0 thereafter. rst asserted after FE,0A (mid-RGB) -> no pixel emitted; then 0x00 -> pix_out=0x000 (table cleared).
6. With QOI_DEC_PIXLIMIT_EN and NUM_PIXELS=4: FE,01,23 then C5 -> exactly 4 beats of 0x123, then done=1.
